// File: rtl/pool2x2_window_gen.sv
// Streaming 2x2 stride-2 window builder: buffers each even row, pairs it with the following
// odd row and emits non-overlapping (a,b,c,d) windows through a single output register.
module pool2x2_window_gen #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic [DATA_W-1:0]              pix_in,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    output logic [DATA_W-1:0]              win_a,
    output logic [DATA_W-1:0]              win_b,
    output logic [DATA_W-1:0]              win_c,
    output logic [DATA_W-1:0]              win_d,
    output logic                           win_valid,
    input  logic                           win_ready,
    output logic [$clog2(IMG_H/2+1)-1:0]   win_row,
    output logic [$clog2(IMG_W/2+1)-1:0]   win_col,
    output logic                           frame_done
);

    localparam int unsigned ColW  = $clog2(IMG_W);
    localparam int unsigned RowW  = $clog2(IMG_H);
    localparam int unsigned WRowW = $clog2(IMG_H/2+1);
    localparam int unsigned WColW = $clog2(IMG_W/2+1);

    typedef enum logic {StTop, StBot} state_e;

    state_e             state_q, state_d;
    logic [ColW-1:0]    col_q, col_d;
    logic [RowW-1:0]    row_q, row_d;
    logic [DATA_W-1:0]  bl_q, bl_d;
    logic [DATA_W-1:0]  win_a_q, win_a_d;
    logic [DATA_W-1:0]  win_b_q, win_b_d;
    logic [DATA_W-1:0]  win_c_q, win_c_d;
    logic [DATA_W-1:0]  win_d_q, win_d_d;
    logic [WRowW-1:0]   win_row_q, win_row_d;
    logic [WColW-1:0]   win_col_q, win_col_d;
    logic               win_valid_q, win_valid_d;
    logic               frame_done_q, frame_done_d;
    logic [DATA_W-1:0]  linebuf_q [IMG_W];

    logic accept;
    logic col_last;
    logic row_last;

    // Single output stage: a pending window back-pressures the pixel stream.
    assign pix_ready = !clear && (!win_valid_q || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign col_last  = (col_q == ColW'(IMG_W - 1));
    assign row_last  = (row_q == RowW'(IMG_H - 1));

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        bl_d         = bl_q;
        win_a_d      = win_a_q;
        win_b_d      = win_b_q;
        win_c_d      = win_c_q;
        win_d_d      = win_d_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        win_valid_d  = win_valid_q;
        frame_done_d = 1'b0;
        if (clear) begin
            state_d     = StTop;
            col_d       = '0;
            row_d       = '0;
            win_valid_d = 1'b0;
        end else begin
            if (win_valid_q && win_ready) begin
                win_valid_d = 1'b0;
            end
            if (accept) begin
                if (col_last) begin
                    col_d = '0;
                    if (row_last) begin
                        row_d        = '0;
                        state_d      = StTop;
                        frame_done_d = 1'b1;
                    end else begin
                        row_d   = row_q + RowW'(1);
                        state_d = (state_q == StTop) ? StBot : StTop;
                    end
                end else begin
                    col_d = col_q + ColW'(1);
                end
                // Odd-width trailing column lands on an even col and is never windowed.
                if (state_q == StBot) begin
                    if (col_q[0]) begin
                        win_a_d     = linebuf_q[col_q - ColW'(1)];
                        win_b_d     = linebuf_q[col_q];
                        win_c_d     = bl_q;
                        win_d_d     = pix_in;
                        win_row_d   = WRowW'(row_q >> 1);
                        win_col_d   = WColW'(col_q >> 1);
                        win_valid_d = 1'b1;
                    end else begin
                        bl_d = pix_in;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StTop;
            col_q        <= '0;
            row_q        <= '0;
            bl_q         <= '0;
            win_a_q      <= '0;
            win_b_q      <= '0;
            win_c_q      <= '0;
            win_d_q      <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            bl_q         <= bl_d;
            win_a_q      <= win_a_d;
            win_b_q      <= win_b_d;
            win_c_q      <= win_c_d;
            win_d_q      <= win_d_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer holds data only; its contents need no reset.
    always_ff @(posedge clk) begin
        if (accept && (state_q == StTop)) begin
            linebuf_q[col_q] <= pix_in;
        end
    end

    assign win_a      = win_a_q;
    assign win_b      = win_b_q;
    assign win_c      = win_c_q;
    assign win_d      = win_d_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool2x2_window_gen.sv
// Directed bench for pool2x2_window_gen: a 4x4 instance for the main cases and a 5x3
// instance for odd-dimension discard behaviour.
module tb_pool2x2_window_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        c4, pv4, pr4, wv4, wr4, fd4;
    logic [15:0] pi4, a4, b4, cc4, d4;
    logic [1:0]  row4, col4;
    logic        c5, pv5, pr5, wv5, wr5, fd5;
    logic [15:0] pi5, a5, b5, cc5, d5;
    logic [0:0]  row5;
    logic [1:0]  col5;

    pool2x2_window_gen #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .clear(c4), .pix_in(pi4), .pix_valid(pv4),
        .pix_ready(pr4), .win_a(a4), .win_b(b4), .win_c(cc4), .win_d(d4),
        .win_valid(wv4), .win_ready(wr4), .win_row(row4), .win_col(col4),
        .frame_done(fd4)
    );

    pool2x2_window_gen #(.DATA_W(16), .IMG_W(5), .IMG_H(3)) u_dut53 (
        .clk(clk), .rst_n(rst_n), .clear(c5), .pix_in(pi5), .pix_valid(pv5),
        .pix_ready(pr5), .win_a(a5), .win_b(b5), .win_c(cc5), .win_d(d5),
        .win_valid(wv5), .win_ready(wr5), .win_row(row5), .win_col(col5),
        .frame_done(fd5)
    );

    logic [71:0] pk4, pk5;
    assign pk4 = {a4, b4, cc4, d4, 4'(row4), 4'(col4)};
    assign pk5 = {a5, b5, cc5, d5, 4'(row5), 4'(col5)};

    int vectors = 0;
    int miscompares = 0;
    logic [71:0] q4[$];
    logic [71:0] q5[$];
    logic [71:0] ew[$];
    int fdn4 = 0;
    int fdn5 = 0;

    // Record every window handshake and frame_done pulse.
    always @(negedge clk) begin
        if (wv4 && wr4) q4.push_back(pk4);
        if (wv5 && wr5) q5.push_back(pk5);
        if (fd4) fdn4++;
        if (fd5) fdn5++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] wp(input logic [15:0] a, b, c, d, input int r, input int k);
        logic [3:0] r4, k4;
        r4 = r[3:0];
        k4 = k[3:0];
        return {a, b, c, d, r4, k4};
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [15:0] v);
        int n;
        pv4 = 1'b1;
        pi4 = v;
        for (n = 0; n < 64; n++) begin
            @(negedge clk);
            if (pr4) break;
        end
        if (n == 64) check("send4_timeout", 72'(pr4), 72'd1);
        @(posedge clk);
        #1;
        pv4 = 1'b0;
    endtask

    task automatic send5(input logic [15:0] v);
        int n;
        pv5 = 1'b1;
        pi5 = v;
        for (n = 0; n < 64; n++) begin
            @(negedge clk);
            if (pr5) break;
        end
        if (n == 64) check("send5_timeout", 72'(pr5), 72'd1);
        @(posedge clk);
        #1;
        pv5 = 1'b0;
    endtask

    task automatic load_case1();
        ew.delete();
        ew.push_back(wp(16'h0, 16'h1, 16'h4, 16'h5, 0, 0));
        ew.push_back(wp(16'h2, 16'h3, 16'h6, 16'h7, 0, 1));
        ew.push_back(wp(16'h8, 16'h9, 16'hC, 16'hD, 1, 0));
        ew.push_back(wp(16'hA, 16'hB, 16'hE, 16'hF, 1, 1));
    endtask

    task automatic check_q4(input string tag);
        logic [71:0] got;
        check({tag, "_count"}, 72'(q4.size()), 72'(ew.size()));
        for (int i = 0; i < ew.size(); i++) begin
            got = (i < q4.size()) ? q4[i] : '0;
            check($sformatf("%s_win%0d", tag, i), got, ew[i]);
        end
    endtask

    logic [15:0] vals [4];
    int fd_base;

    initial begin
        vals[0] = 16'h3C00; vals[1] = 16'h4000; vals[2] = 16'h4200; vals[3] = 16'h4400;
        rst_n = 1'b0;
        c4 = 1'b0; pv4 = 1'b0; pi4 = '0; wr4 = 1'b1;
        c5 = 1'b0; pv5 = 1'b0; pi5 = '0; wr5 = 1'b1;
        #3;
        check("reset_win_valid", 72'(wv4), 72'd0);
        check("reset_win", pk4, 72'd0);
        check("reset_frame_done", 72'(fd4), 72'd0);
        check("reset_pix_ready", 72'(pr4), 72'd1);
        #9;
        rst_n = 1'b1;
        step();

        // Case 1: plain 4x4 frame, downstream always ready.
        q4.delete();
        fd_base = fdn4;
        for (int i = 0; i < 16; i++) begin
            send4(16'(i));
            if (i == 5) check("c1_latency", {71'(pk4), 1'b0} | 72'(wv4), {71'(wp(16'h0, 16'h1, 16'h4, 16'h5, 0, 0)), 1'b1});
            if (i == 15) check("c1_frame_done", 72'(fd4), 72'd1);
        end
        step();
        check("c1_frame_done_pulse", 72'(fd4), 72'd0);
        step();
        load_case1();
        check_q4("c1");
        check("c1_fd_count", 72'(fdn4 - fd_base), 72'd1);

        // Case 2: downstream stalls for 5 cycles on the first window.
        q4.delete();
        for (int i = 0; i < 5; i++) send4(16'(i));
        wr4 = 1'b0;
        send4(16'h5);
        pv4 = 1'b1;
        pi4 = 16'h6;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("c2_stall_pix_ready", 72'(pr4), 72'd0);
            check("c2_stall_hold", {pk4[71:1], wv4}, {71'(wp(16'h0, 16'h1, 16'h4, 16'h5, 0, 0) >> 1), 1'b1});
        end
        @(posedge clk);
        #1;
        wr4 = 1'b1;
        for (int i = 6; i < 16; i++) send4(16'(i));
        step();
        step();
        check_q4("c2");

        // Case 3: 5x3 frame drops the last column and the last row.
        q5.delete();
        for (int i = 0; i < 15; i++) begin
            send5(16'(i));
            if (i == 14) check("c3_frame_done", 72'(fd5), 72'd1);
        end
        step();
        step();
        check("c3_count", 72'(q5.size()), 72'd2);
        check("c3_win0", (q5.size() > 0) ? q5[0] : '0, wp(16'h0, 16'h1, 16'h5, 16'h6, 0, 0));
        check("c3_win1", (q5.size() > 1) ? q5[1] : '0, wp(16'h2, 16'h3, 16'h7, 16'h8, 0, 1));
        check("c3_fd_count", 72'(fdn5), 72'd1);

        // Case 4: two back-to-back frames of repeating fp16 values.
        q4.delete();
        fd_base = fdn4;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) send4(vals[c]);
        step();
        step();
        ew.delete();
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) ew.push_back(wp(16'h3C00, 16'h4000, 16'h3C00, 16'h4000, (k / 2) % 2, 0));
            else            ew.push_back(wp(16'h4200, 16'h4400, 16'h4200, 16'h4400, (k / 2) % 2, 1));
        end
        check_q4("c4");
        check("c4_fd_count", 72'(fdn4 - fd_base), 72'd2);

        // Case 5: asynchronous reset mid-frame with a window pending.
        wr4 = 1'b0;
        for (int i = 0; i < 6; i++) send4(16'(i));
        check("c5_pending", 72'(wv4), 72'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("c5_rst_win_valid", 72'(wv4), 72'd0);
        check("c5_rst_win", pk4, 72'd0);
        check("c5_rst_frame_done", 72'(fd4), 72'd0);
        #3;
        rst_n = 1'b1;
        wr4 = 1'b1;
        q4.delete();
        step();
        for (int i = 0; i < 16; i++) send4(16'(i));
        step();
        step();
        load_case1();
        check_q4("c5");

        // Case 6: clear with a pending window and a pixel presented.
        for (int i = 0; i < 7; i++) send4(16'(i));
        wr4 = 1'b0;
        send4(16'h7);
        check("c6_pending", 72'(wv4), 72'd1);
        fd_base = fdn4;
        c4 = 1'b1;
        wr4 = 1'b1;
        pv4 = 1'b1;
        pi4 = 16'h00AA;
        @(negedge clk);
        check("c6_clear_pix_ready", 72'(pr4), 72'd0);
        @(posedge clk);
        #1;
        c4 = 1'b0;
        pv4 = 1'b0;
        check("c6_win_valid", 72'(wv4), 72'd0);
        check("c6_frame_done", 72'(fd4), 72'd0);
        q4.delete();
        for (int i = 0; i < 16; i++) send4(16'(i));
        step();
        step();
        load_case1();
        check_q4("c6");
        check("c6_fd_count", 72'(fdn4 - fd_base), 72'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
